johnson_phase_tracker: RTL and testbench
========================================

// Module: johnson_phase_tracker
// PURPOSE
//  Downstream consumer of the 4-stage Johnson counter. Samples the counter code, decodes it to a binary
//  phase index (0..2N-1), flags illegal codes and sequence breaks, and tracks lock via a small FSM.
//  Feeds phase/wrap to timing logic and error status to monitoring.
// PARAMETERS
//  N          4   Johnson stages; code width N, phase range 0..2N-1
//  LOCK_CNT   4   consecutive good samples needed to enter LOCKED (>=1)
//  ERR_CNT_W  8   width of saturating error counter
// PORTS
//  clk        in   1          single clock, rising edge
//  rst        in   1          synchronous, active-low reset
//  jc_in      in   N          Johnson code from counter
//  jc_valid   in   1          jc_in sampled this cycle
//  phase      out  PW         decoded phase, PW = $clog2(2N)
//  phase_vld  out  1          phase valid, registered
//  illegal    out  1          1-cycle pulse: sampled code not a legal Johnson code
//  seq_err    out  1          1-cycle pulse: legal code but not predecessor+1 mod 2N
//  wrap       out  1          1-cycle pulse: legal step 2N-1 -> 0
//  locked     out  1          FSM in LOCKED
//  err_count  out  ERR_CNT_W  saturating count of illegal|seq_err events
// BEHAVIOUR
//  - Reset (rst==0 at posedge): all outputs 0, FSM=UNLOCKED, good-run counter 0, reference phase invalid.
//    Reset mid-operation discards any in-flight sample; it takes effect at that edge regardless of jc_valid.
//  - Decode: MSB=1 -> count c of contiguous ones from MSB, phase=c-1; MSB=0 -> count z of contiguous zeros
//    from MSB, phase=N-1+z. Legal iff remaining bits are the complement run. N=4: 1000=0,1100=1,1110=2,
//    1111=3,0111=4,0011=5,0001=6,0000=7; any other code illegal.
//  - Latency 1: jc_valid at edge k -> phase/phase_vld/flags at edge k+1. jc_valid=0 -> phase_vld=0, pulses 0,
//    phase holds last value, FSM and reference unchanged.
//  - Illegal code: illegal=1, seq_err=0, phase_vld=0, reference invalidated. One event counted.
//  - Legal code, reference invalid: no sequence check, seq_err=0; becomes reference.
//  - Legal code, reference valid: expected=(ref+1) mod 2N; mismatch (incl. repeat) -> seq_err=1; reference
//    updated to new phase either way. wrap=1 only when ref=2N-1 and phase=0.
//  - err_count += 1 per event (illegal or seq_err, never 2 in one cycle); saturates at all-ones, no wrap.
//  - FSM: UNLOCKED -(good sample)-> ACQUIRE; ACQUIRE: good samples increment run; run==LOCK_CNT -> LOCKED
//    (LOCK_CNT=1 goes UNLOCKED->LOCKED directly); any illegal/seq_err in ACQUIRE or LOCKED -> UNLOCKED, run=0.
//    "Good" = legal and (no reference or sequential). locked=1 exactly in LOCKED, registered.
// CONFIGURATION
//  JPT_ONEHOT_EN defined: extra output phase_oh [2N-1:0] = one-hot of phase, registered with phase,
//    all-zero when phase_vld=0 and at reset.
//  Not defined: port phase_oh absent; no one-hot logic synthesised. All other behaviour identical.
// STRUCTURE
//  Package johnson_pkg: lock-FSM state enum (UNLOCKED, ACQUIRE, LOCKED), phase width function
//    jpt_pw(N)=$clog2(2N), legal-code/decode function shared with other Johnson consumers.
//  Sub-module johnson_code_decode: combinational jc -> {legal, phase}; tracker instantiates one.
// TESTING
//  1. Reset then feed 1000,1100,...,0000,1000 with jc_valid=1 -> phase 0..7,0; wrap once at 7->0;
//     locked=1 after 4th good sample; err_count=0.
//  2. Locked, inject 1010 -> next cycle illegal=1, phase_vld=0, locked=0, err_count=1; resume 1100,1110 ->
//     no seq_err (reference invalid then re-established).
//  3. Locked at phase 2, feed 1110 again (repeat) -> seq_err=1, locked=0; feed 0011 next -> seq_err=1,
//     err_count=2.
//  4. Toggle jc_valid 1,0,0,1 on consecutive codes -> gaps produce no flags, phase holds, sequence accepted.
//  5. ERR_CNT_W=2, inject 5 illegal codes -> err_count 1,2,3,3,3.
//  6. Assert rst=0 mid-run while locked with jc_valid=1 -> next edge all outputs 0, locked=0; with
//     JPT_ONEHOT_EN, phase_oh tracks 1<<phase in scenario 1 and is 0 after reset.

Source files
------------

// File: rtl/johnson_pkg.sv
// Shared definitions for consumers of an N-stage Johnson counter: lock-FSM states,
// phase width helper and the legal-code/decode function.
package johnson_pkg;

    // Widest Johnson code the shared decode function accepts.
    localparam int JPT_MAX_N = 16;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } lock_state_e;

    function automatic int jpt_pw(input int n);
        return $clog2(2 * n);
    endfunction

    // The code is left-aligned so the run is always measured from bit JPT_MAX_N-1;
    // the run length gives the phase and any bit equal to the MSB after the run is illegal.
    function automatic logic jpt_decode(input logic [JPT_MAX_N-1:0] code,
                                        input int n,
                                        output int phase);
        logic [JPT_MAX_N-1:0] bits;
        logic msb;
        logic in_run;
        logic legal;
        int   run;
        bits   = code << (JPT_MAX_N - n);
        msb    = bits[JPT_MAX_N-1];
        in_run = 1'b1;
        legal  = 1'b1;
        run    = 0;
        for (int i = 0; i < JPT_MAX_N; i++) begin
            if (i < n) begin
                if (in_run && (bits[JPT_MAX_N-1] == msb)) begin
                    run = run + 1;
                end else begin
                    in_run = 1'b0;
                    if (bits[JPT_MAX_N-1] == msb) legal = 1'b0;
                end
                bits = bits << 1;
            end
        end
        phase = msb ? (run - 1) : (n - 1 + run);
        return legal;
    endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson code decoder: jc -> {legal, phase index 0..2N-1}.
module johnson_code_decode
    import johnson_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = jpt_pw(N)
) (
    input  logic [N-1:0]  jc_i,
    output logic          legal_o,
    output logic [PW-1:0] phase_o
);

    int phase_int;

    always_comb begin
        phase_int = 0;
        legal_o   = jpt_decode(JPT_MAX_N'(jc_i), N, phase_int);
        phase_o   = PW'(phase_int);
    end

endmodule

// File: rtl/johnson_phase_tracker.sv
// Samples a Johnson counter code, decodes phase, flags illegal codes and sequence breaks,
// and tracks lock. Optional macro JPT_ONEHOT_EN adds the registered one-hot output phase_oh.
module johnson_phase_tracker
    import johnson_pkg::*;
#(
    parameter int N         = 4,
    parameter int LOCK_CNT  = 4,
    parameter int ERR_CNT_W = 8,
    localparam int PW       = jpt_pw(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         jc_in,
    input  logic                 jc_valid,
    output logic [PW-1:0]        phase,
    output logic                 phase_vld,
    output logic                 illegal,
    output logic                 seq_err,
    output logic                 wrap,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_count
`ifdef JPT_ONEHOT_EN
    ,
    output logic [2*N-1:0]       phase_oh
`endif
);

    localparam int PHASES = 2 * N;
    localparam int RW     = $clog2(LOCK_CNT + 1);
    localparam logic [PW-1:0]        LAST_PHASE = PW'(PHASES - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX    = '1;

    logic          dec_legal;
    logic [PW-1:0] dec_phase;

    johnson_code_decode #(.N(N)) u_decode (
        .jc_i    (jc_in),
        .legal_o (dec_legal),
        .phase_o (dec_phase)
    );

    logic [PW-1:0]        phase_q, phase_d;
    logic                 phase_vld_q, phase_vld_d;
    logic                 illegal_q, illegal_d;
    logic                 seq_err_q, seq_err_d;
    logic                 wrap_q, wrap_d;
    logic [PW-1:0]        ref_q, ref_d;
    logic                 ref_vld_q, ref_vld_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    lock_state_e          state_q, state_d;
    logic [RW-1:0]        run_q, run_d;
    logic [RW-1:0]        run_inc;

    logic [PW-1:0] expect_phase;
    logic          in_seq;
    logic          good;
    logic          bad;

    // Without a reference any legal code counts as sequential.
    assign expect_phase = (ref_q == LAST_PHASE) ? '0 : ref_q + PW'(1);
    assign in_seq       = !ref_vld_q || (dec_phase == expect_phase);
    assign good         = jc_valid && dec_legal && in_seq;
    assign bad          = jc_valid && !(dec_legal && in_seq);
    assign run_inc      = run_q + RW'(1);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        phase_d     = phase_q;
        phase_vld_d = 1'b0;
        illegal_d   = 1'b0;
        seq_err_d   = 1'b0;
        wrap_d      = 1'b0;
        ref_d       = ref_q;
        ref_vld_d   = ref_vld_q;
        err_d       = err_q;
        if (jc_valid) begin
            if (!dec_legal) begin
                illegal_d = 1'b1;
                ref_vld_d = 1'b0;
            end else begin
                phase_d     = dec_phase;
                phase_vld_d = 1'b1;
                seq_err_d   = !in_seq;
                wrap_d      = ref_vld_q && (ref_q == LAST_PHASE) && (dec_phase == '0);
                ref_d       = dec_phase;
                ref_vld_d   = 1'b1;
            end
            if (bad && (err_q != ERR_MAX)) err_d = err_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            phase_q     <= '0;
            phase_vld_q <= 1'b0;
            illegal_q   <= 1'b0;
            seq_err_q   <= 1'b0;
            wrap_q      <= 1'b0;
            ref_q       <= '0;
            ref_vld_q   <= 1'b0;
            err_q       <= '0;
        end else begin
            phase_q     <= phase_d;
            phase_vld_q <= phase_vld_d;
            illegal_q   <= illegal_d;
            seq_err_q   <= seq_err_d;
            wrap_q      <= wrap_d;
            ref_q       <= ref_d;
            ref_vld_q   <= ref_vld_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= UNLOCKED;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        case (state_q)
            UNLOCKED: begin
                if (good) begin
                    run_d   = RW'(1);
                    state_d = (LOCK_CNT == 1) ? LOCKED : ACQUIRE;
                end
            end
            ACQUIRE: begin
                if (bad) begin
                    state_d = UNLOCKED;
                    run_d   = '0;
                end else if (good) begin
                    run_d = run_inc;
                    if (run_inc == RW'(LOCK_CNT)) state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (bad) begin
                    state_d = UNLOCKED;
                    run_d   = '0;
                end
            end
            default: begin
                state_d = UNLOCKED;
                run_d   = '0;
            end
        endcase
    end

    always_comb begin
        locked = (state_q == LOCKED);
    end

    assign phase     = phase_q;
    assign phase_vld = phase_vld_q;
    assign illegal   = illegal_q;
    assign seq_err   = seq_err_q;
    assign wrap      = wrap_q;
    assign err_count = err_q;

`ifdef JPT_ONEHOT_EN
    logic [PHASES-1:0] phase_oh_q, phase_oh_d;

    always_comb begin
        phase_oh_d = '0;
        if (phase_vld_d) phase_oh_d[phase_d] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) phase_oh_q <= '0;
        else      phase_oh_q <= phase_oh_d;
    end

    assign phase_oh = phase_oh_q;
`else
    // Default build carries no one-hot register.
`endif

endmodule

// File: tb/tb_johnson_phase_tracker.sv
// Scoreboard bench for johnson_phase_tracker: directed scenarios plus random codes,
// checked against a table-based reference model; a second instance covers LOCK_CNT=1, ERR_CNT_W=2.
module tb_johnson_phase_tracker;

    localparam int N      = 4;
    localparam int PHASES = 2 * N;
    localparam int PW     = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         jc_valid;
    logic [N-1:0] jc_in;

    logic [PW-1:0] phase, phase2;
    logic          phase_vld, illegal, seq_err, wrap, locked;
    logic          phase_vld2, illegal2, seq_err2, wrap2, locked2;
    logic [7:0]    err_count;
    logic [1:0]    err_count2;
`ifdef JPT_ONEHOT_EN
    logic [PHASES-1:0] phase_oh, phase_oh2;
`endif

    always #5 clk = ~clk;

    johnson_phase_tracker #(.N(N), .LOCK_CNT(4), .ERR_CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .jc_in     (jc_in),
        .jc_valid  (jc_valid),
        .phase     (phase),
        .phase_vld (phase_vld),
        .illegal   (illegal),
        .seq_err   (seq_err),
        .wrap      (wrap),
        .locked    (locked),
        .err_count (err_count)
`ifdef JPT_ONEHOT_EN
        ,
        .phase_oh  (phase_oh)
`endif
    );

    johnson_phase_tracker #(.N(N), .LOCK_CNT(1), .ERR_CNT_W(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .jc_in     (jc_in),
        .jc_valid  (jc_valid),
        .phase     (phase2),
        .phase_vld (phase_vld2),
        .illegal   (illegal2),
        .seq_err   (seq_err2),
        .wrap      (wrap2),
        .locked    (locked2),
        .err_count (err_count2)
`ifdef JPT_ONEHOT_EN
        ,
        .phase_oh  (phase_oh2)
`endif
    );

    typedef struct {
        logic [PW-1:0]     phase;
        logic              vld;
        logic              ill;
        logic              seq;
        logic              wrp;
        logic              lck;
        logic [7:0]        err;
        logic              lck2;
        logic [1:0]        err2;
        logic [PHASES-1:0] oh;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    bit m_ref_vld;
    int m_ref;
    int m_phase;
    int m_run;
    int m_err;
    int m_err2;

    logic [N-1:0] ill_codes [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Johnson code for phase p: p+1 ones from the MSB, then runs of zeros from the MSB.
    function automatic logic [N-1:0] code_of(input int p);
        int v;
        int z;
        if (p < N) begin
            v = ((1 << (p + 1)) - 1) << (N - p - 1);
        end else begin
            z = p - N + 1;
            v = (1 << (N - z)) - 1;
        end
        return N'(v);
    endfunction

    function automatic int phase_of(input logic [N-1:0] c);
        for (int p = 0; p < PHASES; p++) begin
            if (code_of(p) == c) return p;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic v, input logic [N-1:0] c);
        exp_t e;
        int   p;
        bit   bad;
        e.vld = 1'b0;
        e.ill = 1'b0;
        e.seq = 1'b0;
        e.wrp = 1'b0;
        bad   = 1'b0;
        if (!r) begin
            m_ref_vld = 1'b0;
            m_ref     = 0;
            m_phase   = 0;
            m_run     = 0;
            m_err     = 0;
            m_err2    = 0;
        end else if (v) begin
            p = phase_of(c);
            if (p < 0) begin
                e.ill     = 1'b1;
                m_ref_vld = 1'b0;
                bad       = 1'b1;
            end else begin
                if (m_ref_vld && (p != (m_ref + 1) % PHASES)) begin
                    e.seq = 1'b1;
                    bad   = 1'b1;
                end
                e.wrp     = m_ref_vld && (m_ref == PHASES - 1) && (p == 0);
                m_ref     = p;
                m_ref_vld = 1'b1;
                m_phase   = p;
                e.vld     = 1'b1;
            end
            if (bad) begin
                m_run  = 0;
                m_err  = (m_err  < 255) ? m_err  + 1 : 255;
                m_err2 = (m_err2 < 3)   ? m_err2 + 1 : 3;
            end else if (m_run < 1000) begin
                m_run = m_run + 1;
            end
        end
        e.phase = PW'(m_phase);
        e.lck   = (m_run >= 4);
        e.lck2  = (m_run >= 1);
        e.err   = 8'(m_err);
        e.err2  = 2'(m_err2);
        e.oh    = e.vld ? PHASES'(1 << m_phase) : '0;
        exp_q.push_back(e);
    endtask

    // Drive one sample, let the edge consume it, then queue the model's expectation.
    task automatic step(input logic r, input logic v, input logic [N-1:0] c);
        rst      = r;
        jc_valid = v;
        jc_in    = c;
        @(posedge clk);
        model_step(r, v, c);
        #1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("phase",     32'(phase),     32'(e.phase));
                check("phase_vld", 32'(phase_vld), 32'(e.vld));
                check("illegal",   32'(illegal),   32'(e.ill));
                check("seq_err",   32'(seq_err),   32'(e.seq));
                check("wrap",      32'(wrap),      32'(e.wrp));
                check("locked",    32'(locked),    32'(e.lck));
                check("err_count", 32'(err_count), 32'(e.err));
                check("lock1_locked", 32'(locked2),    32'(e.lck2));
                check("errw2_count",  32'(err_count2), 32'(e.err2));
                check("inst2_phase",  32'(phase2),     32'(e.phase));
                check("inst2_flags",  32'({phase_vld2, illegal2, seq_err2, wrap2}),
                      32'({e.vld, e.ill, e.seq, e.wrp}));
`ifdef JPT_ONEHOT_EN
                check("phase_oh",  32'(phase_oh),  32'(e.oh));
                check("inst2_oh",  32'(phase_oh2), 32'(e.oh));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cur;
        int kind;
        int pc;
        logic v;
        logic r;
        logic [N-1:0] c;

        ill_codes[0] = 4'b1010;
        ill_codes[1] = 4'b0101;
        ill_codes[2] = 4'b1001;
        ill_codes[3] = 4'b0110;
        ill_codes[4] = 4'b1101;
        rst      = 1'b0;
        jc_valid = 1'b0;
        jc_in    = '0;

        // Reset, including reset winning over a valid sample
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 4'b1010);

        // Full cycle 0..7 then 0: wrap and lock after the 4th good sample
        for (int p = 0; p <= PHASES; p++) step(1'b1, 1'b1, code_of(p % PHASES));

        // Illegal code while locked, then re-establish reference
        step(1'b1, 1'b1, 4'b1010);
        step(1'b1, 1'b1, code_of(1));
        step(1'b1, 1'b1, code_of(2));

        // Relock and come back to phase 2, then a repeat and a skip
        for (int p = 3; p <= PHASES + 2; p++) step(1'b1, 1'b1, code_of(p % PHASES));
        step(1'b1, 1'b1, code_of(2));
        step(1'b1, 1'b1, code_of(5));

        // Gaps in jc_valid hold phase and raise no flags
        step(1'b1, 1'b1, code_of(6));
        step(1'b1, 1'b0, code_of(1));
        step(1'b1, 1'b0, 4'b1010);
        step(1'b1, 1'b1, code_of(7));

        // Error counter saturation on the narrow instance
        step(1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, ill_codes[i]);

        // Reset while locked with a valid sample present
        step(1'b0, 1'b0, '0);
        for (int p = 0; p < 6; p++) step(1'b1, 1'b1, code_of(p));
        step(1'b0, 1'b1, code_of(6));
        step(1'b1, 1'b0, '0);

        // Randomized traffic
        cur = 0;
        for (int i = 0; i < 600; i++) begin
            r    = ($urandom_range(0, 99) >= 2);
            v    = ($urandom_range(0, 4) != 0);
            kind = int'($urandom_range(0, 9));
            if (kind <= 5)      c = code_of((cur + 1) % PHASES);
            else if (kind == 6) c = code_of(cur);
            else if (kind == 7) c = code_of(int'($urandom_range(0, PHASES - 1)));
            else                c = N'($urandom_range(0, (1 << N) - 1));
            pc = phase_of(c);
            if (r && v && (pc >= 0)) cur = pc;
            step(r, v, c);
        end

        step(1'b1, 1'b0, '0);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
